decode_pack: RTL and testbench
==============================

# decode_pack

Parametrised output packer for the LZS decompressor. It takes the byte stream leaving the decode engine and packs it little-endian into BYTES-wide words, with per-byte enables and an end-of-stream marker. A small output FIFO provides valid/ready backpressure toward the DMA/bus side. It replaces the fixed 2-byte, no-backpressure output stage of the decode path.

## Interface
Parameters:
- BYTES, 4, bytes per output word; power of two, 2..16.
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- out_valid  in  1  decode engine presents a byte on out_data.
- out_data  in  8  decoded byte.
- out_done  in  1  end of stream; may coincide with the final byte.
- out_ready  out  1  packer accepts out_valid/out_done this cycle.
- data_o  out  8*BYTES  packed word; byte k sits at [8k+7:8k]; the first byte of the word is k=0.
- be_o  out  BYTES  byte enables for data_o.
- last_o  out  1  this word ends the stream.
- valid_o  out  1  word on data_o/be_o/last_o is valid.
- ready_i  in  1  downstream accepts the word.
- done_o  out  1  one-cycle pulse when the last word is accepted.

## Operation
- A byte is accepted when out_valid && out_ready. out_done counts only when out_ready = 1. Upstream holds both signals until accepted.
- Pack register holds a byte count `cnt` (clog2(BYTES) bits, plus a wrap indicator) and a data accumulator.
  - Accepted byte goes to lane `cnt`, then `cnt` increments.
  - On reaching BYTES: push {data, be = all ones, last = 0} to the FIFO, and `cnt` returns to 0.
- Accepted out_done:
  - Push the final word with last = 1 and be = lanes filled so far, including a same-cycle byte.
  - If the same-cycle byte completes a word, push only one word: be = all ones, last = 1.
  - If `cnt` = 0 and no byte arrives that cycle, push a terminator word: be = 0, data = 0, last = 1.
  - Afterwards `cnt` = 0 and the accumulator is cleared, ready for the next stream.
- Unused lanes of a partial word are driven 0.
- out_ready = (FIFO occupancy < FIFO_DEPTH). It is registered-count based: no combinational path from ready_i. A full FIFO blocks input even if it is popping that cycle.
- FIFO pop on valid_o && ready_i. valid_o = FIFO not empty. data_o, be_o and last_o are the FIFO head.
- done_o pulses in the cycle after the pop of a word with last_o = 1.

## Timing
- Reset values: valid_o = 0, last_o = 0, be_o = 0, data_o = 0, done_o = 0, `cnt` = 0, FIFO empty.
- out_ready = 0 while rst is high, and 1 in the first cycle after rst deasserts.
- Latency: a byte completing a word (or an accepted done) in cycle N gives valid_o = 1 in cycle N+1 when the FIFO was empty.
- Throughput: one byte per cycle sustained while ready_i stays high.
- Simultaneous push and pop with the FIFO not full: occupancy unchanged, both happen.
- Pointer wrap at FIFO_DEPTH is seamless, with no bubble.
- rst mid-stream drops the partial word and all FIFO contents. No done_o is produced for the dropped stream.
- Output-side stall: when valid_o = 1 and ready_i = 0, data_o/be_o/last_o hold stable until accepted.

## Structure
- Shared package/header `decode_pkg` holds:
  - constant BYTE_W = 8;
  - a clog2 function;
  - the FIFO entry layout {last, be, data}, width 8*BYTES + BYTES + 1.
- Sub-module `decode_out_fifo`: parametrised synchronous FIFO (WIDTH, DEPTH) with registered count and full/empty flags.
- The top level keeps the pack register, lane steering and done-pulse logic.

## Test plan
- BYTES=4, ready_i=1; bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then out_done alone -> word 0x44332211 with be=0xF, last=0. Then terminator with be=0x0, last=1, and done_o one cycle after its pop.
- BYTES=4; bytes 0xA1, 0xA2, 0xA3 with out_done on the 0xA3 cycle -> single word 0x00A3A2A1, be=0x7, last=1.
- BYTES=4; eight bytes, with out_done on the eighth -> two words, be=0xF both, last only on the second, exactly one done_o.
- FIFO_DEPTH=4, ready_i=0; stream 20 bytes -> out_ready drops after the 16th accepted byte. Releasing ready_i drains 4 words in order with no loss or duplication.
- Random ready_i toggling over a 1000-byte stream, BYTES=2 and 8 -> output bytes match input order, and data_o/be_o/last_o stay stable during stalls.
- Assert rst after 3 bytes of a word with 2 words queued -> next cycle valid_o=0 and `cnt`=0. A new stream of 4 bytes yields exactly one fresh word.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the decoder output packer.
//   BYTE_W      : width of one decoded byte lane.
//   clog2()     : ceiling log2 for sizing counters and pointers.
//   entry_w()   : width of one output FIFO entry laid out as {last, be, data},
//                 where data is BYTE_W*bytes wide, be is bytes wide and last is 1 bit.
package decode_pkg;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned data_w(input int unsigned bytes);
    return BYTE_W * bytes;
  endfunction

  function automatic int unsigned entry_w(input int unsigned bytes);
    return BYTE_W * bytes + bytes + 1;
  endfunction

endpackage

// File: rtl/decode_out_fifo.sv
// Synchronous FIFO with a registered occupancy count.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push_i    : write wdata_i (ignored when full)
//   wdata_i   : entry to write
//   pop_i     : drop the head entry (ignored when empty)
//   rdata_o   : head entry; forced to zero while empty
//   empty_o   : no entries held
//   full_o    : DEPTH entries held
module decode_out_fifo
  import decode_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);
  localparam logic [PtrW:0] CntOne = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FullCnt);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Zeroing the head while empty keeps the output word at 0 after reset.
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    // DEPTH is a power of two, so pointer wrap is plain overflow.
    if (push_ok) wptr_d = wptr_q + PtrOne;
    if (pop_ok)  rptr_d = rptr_q + PtrOne;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/decode_pack.sv
// Packs the decoder byte stream little-endian into BYTES-wide words with byte
// enables and an end-of-stream flag, buffered by a small output FIFO.
//   clk, rst   : clock, synchronous active-high reset (drops partial word and FIFO)
//   out_valid  : upstream byte present on out_data
//   out_data   : upstream byte
//   out_done   : upstream end of stream (may coincide with the final byte)
//   out_ready  : packer accepts out_valid/out_done this cycle
//   data_o     : packed word, first byte in lane 0
//   be_o       : byte enables for data_o
//   last_o     : word ends the stream
//   valid_o    : word on data_o/be_o/last_o is valid
//   ready_i    : downstream accepts the word
//   done_o     : one-cycle pulse after the last word is accepted
module decode_pack
  import decode_pkg::*;
#(
  parameter int unsigned BYTES      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    out_valid,
  input  logic [BYTE_W-1:0]       out_data,
  input  logic                    out_done,
  output logic                    out_ready,
  output logic [BYTE_W*BYTES-1:0] data_o,
  output logic [BYTES-1:0]        be_o,
  output logic                    last_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    done_o
);

  localparam int unsigned DataW  = data_w(BYTES);
  localparam int unsigned CntW   = clog2(BYTES);
  localparam int unsigned EntryW = entry_w(BYTES);

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DataW-1:0]  acc_q, acc_d, acc_upd;
  logic [CntW:0]     fill;
  logic [BYTES-1:0]  be_part, push_be;
  logic [EntryW-1:0] push_entry, head;
  logic              byte_acc, done_acc, word_full, push, pop;
  logic              fifo_full, fifo_empty;
  logic              done_q;

  // Ready depends only on registered occupancy, never on ready_i.
  assign out_ready = ~rst & ~fifo_full;
  assign byte_acc  = out_valid & out_ready;
  assign done_acc  = out_done & out_ready;

  always_comb begin
    acc_upd = acc_q;
    if (byte_acc) acc_upd[32'(cnt_q) * BYTE_W +: BYTE_W] = out_data;

    // fill counts lanes occupied including a same-cycle byte; its MSB marks a wrap.
    fill      = {1'b0, cnt_q} + (CntW + 1)'(byte_acc);
    word_full = byte_acc && (cnt_q == CntW'(BYTES - 1));

    be_part = '0;
    for (int unsigned k = 0; k < BYTES; k++) begin
      be_part[k] = (32'(fill) > k);
    end

    push       = word_full | done_acc;
    push_be    = word_full ? '1 : be_part;
    push_entry = {done_acc, push_be, acc_upd};

    cnt_d = cnt_q;
    acc_d = acc_q;
    if (push) begin
      // Clearing the accumulator keeps unused lanes of later partial words at 0.
      cnt_d = '0;
      acc_d = '0;
    end else if (byte_acc) begin
      cnt_d = cnt_q + CntW'(1);
      acc_d = acc_upd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      done_q <= pop & last_o;
    end
  end

  decode_out_fifo #(
    .WIDTH (EntryW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign valid_o                = ~fifo_empty;
  assign pop                    = valid_o & ready_i;
  assign {last_o, be_o, data_o} = head;
  assign done_o                 = done_q;

endmodule

// File: tb/tb_decode_pack.sv
module tb_decode_pack;

  typedef logic [72:0] w_t;       // {last, be[7:0], data[63:0]}
  typedef w_t          wq_t[$];
  typedef logic [7:0]  bq_t[$];

  typedef struct packed {
    logic [3:0]  n;
    logic        dalone;
    logic [1:0]  nw;
    logic [95:0] wd;
    logic [11:0] wbe;
    logic [2:0]  wl;
    logic [63:0] bytes;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid [3];
  logic       in_done  [3];
  logic [7:0] in_data  [3];
  logic       rdy      [3];

  logic        ordy0, ordy1, ordy2;
  logic [31:0] d0;
  logic [15:0] d1;
  logic [63:0] d2;
  logic [3:0]  be0;
  logic [1:0]  be1;
  logic [7:0]  be2;
  logic        l0, l1, l2, v0, v1, v2, dn0, dn1, dn2;

  decode_pack #(.BYTES(4), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .out_valid(in_valid[0]), .out_data(in_data[0]),
    .out_done(in_done[0]), .out_ready(ordy0), .data_o(d0), .be_o(be0), .last_o(l0),
    .valid_o(v0), .ready_i(rdy[0]), .done_o(dn0)
  );
  decode_pack #(.BYTES(2), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .out_valid(in_valid[1]), .out_data(in_data[1]),
    .out_done(in_done[1]), .out_ready(ordy1), .data_o(d1), .be_o(be1), .last_o(l1),
    .valid_o(v1), .ready_i(rdy[1]), .done_o(dn1)
  );
  decode_pack #(.BYTES(8), .FIFO_DEPTH(4)) u_dut8 (
    .clk(clk), .rst(rst), .out_valid(in_valid[2]), .out_data(in_data[2]),
    .out_done(in_done[2]), .out_ready(ordy2), .data_o(d2), .be_o(be2), .last_o(l2),
    .valid_o(v2), .ready_i(rdy[2]), .done_o(dn2)
  );

  int checks = 0;
  int errors = 0;

  w_t  capq [3][$];
  w_t  prev_w [3];
  bit  prev_stall [3];
  bit  exp_done [3];
  int  done_cnt [3];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_ordy(input int idx);
    case (idx)
      0:       return ordy0;
      1:       return ordy1;
      default: return ordy2;
    endcase
  endfunction

  // Reference: split the byte stream into nb-byte little-endian words.
  function automatic wq_t model(input int nb, input bq_t bs, input bit done_alone);
    wq_t         r;
    logic [63:0] d;
    logic        lst;
    int          n, full, rem;
    n    = bs.size();
    full = n / nb;
    rem  = n % nb;
    for (int w = 0; w < full; w++) begin
      d = '0;
      for (int k = 0; k < nb; k++) d[8*k +: 8] = bs[w*nb + k];
      lst = (!done_alone && rem == 0 && w == full - 1);
      r.push_back({lst, 8'((1 << nb) - 1), d});
    end
    if (rem > 0) begin
      d = '0;
      for (int k = 0; k < rem; k++) d[8*k +: 8] = bs[full*nb + k];
      r.push_back({1'b1, 8'((1 << rem) - 1), d});
    end else if (done_alone || n == 0) begin
      r.push_back({1'b1, 8'h00, 64'h0});
    end
    return r;
  endfunction

  // Output-side monitor, sampled on the falling edge.
  task automatic mon(input int idx, input logic [63:0] d, input logic [7:0] be,
                     input logic last, input logic valid, input logic done);
    w_t w;
    w = {last, be, d};
    if (rst) begin
      prev_stall[idx] = 0;
      exp_done[idx]   = 0;
      return;
    end
    chk("done_pulse", done, exp_done[idx]);
    if (done) done_cnt[idx]++;
    if (prev_stall[idx]) begin
      chk("stall_valid", valid, 1);
      chk("stall_hold", w, prev_w[idx]);
    end
    if (valid && rdy[idx]) begin
      capq[idx].push_back(w);
      exp_done[idx] = last;
    end else begin
      exp_done[idx] = 0;
    end
    prev_stall[idx] = valid && !rdy[idx];
    prev_w[idx]     = w;
  endtask

  always @(negedge clk) begin
    mon(0, {32'h0, d0}, {4'h0, be0}, l0, v0, dn0);
    mon(1, {48'h0, d1}, {6'h0, be1}, l1, v1, dn1);
    mon(2, d2, be2, l2, v2, dn2);
  end

  // Offer one byte and/or done; returns at posedge+1 after acceptance.
  task automatic put(input int idx, input logic [7:0] b, input bit v, input bit dn);
    int budget;
    bit acc, ok;
    budget        = 5000;
    ok            = 0;
    in_valid[idx] = v;
    in_data[idx]  = b;
    in_done[idx]  = dn;
    while (budget > 0 && !ok) begin
      acc = get_ordy(idx);
      @(posedge clk);
      #1;
      budget--;
      if (acc) ok = 1;
    end
    in_valid[idx] = 0;
    in_done[idx]  = 0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: dut %0d got no acceptance expected acceptance", idx);
    end
  endtask

  task automatic send_stream(input int idx, input bq_t bs, input bit done_alone);
    int n;
    n = bs.size();
    for (int i = 0; i < n; i++) put(idx, bs[i], 1, (!done_alone && i == n - 1));
    if (done_alone || n == 0) put(idx, 8'h00, 0, 1);
  endtask

  task automatic wait_words(input int idx, input int n);
    int budget;
    budget = 20000;
    while (capq[idx].size() < n && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: dut %0d got %0d words expected %0d", idx,
               capq[idx].size(), n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_words(input int idx, input wq_t exp, input string name);
    int n;
    chk({name, "_count"}, capq[idx].size(), exp.size());
    n = (capq[idx].size() < exp.size()) ? capq[idx].size() : exp.size();
    for (int i = 0; i < n; i++) chk(name, capq[idx][i], exp[i]);
    chk({name, "_done_cnt"}, done_cnt[idx], 1);
  endtask

  task automatic clear_cap(input int idx);
    capq[idx].delete();
    done_cnt[idx] = 0;
  endtask

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t bq;
    wq_t exq;
    bit  done_alone, seen_block, stop;
    int  acc, cyc, stall;

    vecs[0] = '{n: 4, dalone: 1, nw: 2, wd: 96'h0_00000000_44332211, wbe: 12'h00F,
                wl: 3'b010, bytes: 64'h44332211};
    vecs[1] = '{n: 3, dalone: 0, nw: 1, wd: 96'h0_00000000_00A3A2A1, wbe: 12'h007,
                wl: 3'b001, bytes: 64'hA3A2A1};
    vecs[2] = '{n: 8, dalone: 0, nw: 2, wd: 96'h0_08070605_04030201, wbe: 12'h0FF,
                wl: 3'b010, bytes: 64'h0807060504030201};
    vecs[3] = '{n: 0, dalone: 1, nw: 1, wd: 96'h0, wbe: 12'h000, wl: 3'b001, bytes: 64'h0};
    vecs[4] = '{n: 5, dalone: 1, nw: 2, wd: 96'h0_00000050_40302010, wbe: 12'h01F,
                wl: 3'b010, bytes: 64'h5040302010};
    vecs[5] = '{n: 6, dalone: 0, nw: 2, wd: 96'h0_0000C6C5_C4C3C2C1, wbe: 12'h03F,
                wl: 3'b010, bytes: 64'hC6C5C4C3C2C1};

    rst = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 0;
      in_done[i]  = 0;
      in_data[i]  = 0;
      rdy[i]      = 0;
      clear_cap(i);
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {v0, v1, v2}, 3'b000);
    chk("rst_data", {d0, d1, d2}, 112'h0);
    chk("rst_be", {be0, be1, be2}, 14'h0);
    chk("rst_last", {l0, l1, l2}, 3'b000);
    chk("rst_done", {dn0, dn1, dn2}, 3'b000);
    chk("rst_out_ready", {ordy0, ordy1, ordy2}, 3'b000);
    rst = 0;
    #1;
    chk("post_rst_ready", {ordy0, ordy1, ordy2}, 3'b111);
    @(posedge clk);
    #1;

    // Table-driven streams on the 4-byte packer, downstream always ready.
    rdy[0] = 1;
    for (int v = 0; v < 6; v++) begin
      bq.delete();
      for (int i = 0; i < int'(vecs[v].n); i++) bq.push_back(vecs[v].bytes[8*i +: 8]);
      clear_cap(0);
      send_stream(0, bq, vecs[v].dalone);
      wait_words(0, int'(vecs[v].nw));
      chk("vec_count", capq[0].size(), vecs[v].nw);
      for (int j = 0; j < int'(vecs[v].nw) && j < capq[0].size(); j++) begin
        chk("vec_word", capq[0][j],
            {vecs[v].wl[j], 4'h0, vecs[v].wbe[4*j +: 4], 32'h0, vecs[v].wd[32*j +: 32]});
      end
      chk("vec_done_cnt", done_cnt[0], 1);
    end

    // Backpressure: FIFO of 4 words fills after 16 bytes, then drains in order.
    rdy[0] = 0;
    clear_cap(0);
    bq.delete();
    acc        = 0;
    cyc        = 0;
    stall      = 0;
    seen_block = 0;
    while (acc < 20 && cyc < 200) begin
      in_valid[0] = 1;
      in_data[0]  = 8'(acc + 8'h60);
      if (get_ordy(0)) begin
        @(posedge clk);
        #1;
        bq.push_back(8'(acc + 8'h60));
        acc++;
        if (acc == 3) chk("latency_partial", v0, 0);
        if (acc == 4) chk("latency_word", v0, 1);
      end else begin
        if (!seen_block) begin
          seen_block = 1;
          chk("block_point", acc, 16);
        end
        @(posedge clk);
        #1;
        stall++;
        if (stall == 5) begin
          chk("still_blocked", ordy0, 0);
          rdy[0] = 1;
        end
      end
      cyc++;
    end
    in_valid[0] = 0;
    put(0, 8'h00, 0, 1);
    exq = model(4, bq, 1);
    wait_words(0, exq.size());
    check_words(0, exq, "bp_word");

    // Reset mid-stream with two words queued and three bytes pending.
    rdy[0] = 0;
    clear_cap(0);
    for (int i = 0; i < 11; i++) put(0, 8'(8'h80 + i), 1, 0);
    chk("pre_rst_valid", v0, 1);
    rst = 1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", v0, 0);
    chk("mid_rst_ready", ordy0, 0);
    chk("mid_rst_data", {l0, be0, d0}, 37'h0);
    rst = 0;
    #1;
    chk("mid_rst_ready_after", ordy0, 1);
    rdy[0] = 1;
    clear_cap(0);
    bq.delete();
    for (int i = 0; i < 4; i++) bq.push_back(8'(8'hD0 + i));
    send_stream(0, bq, 0);
    exq.delete();
    exq.push_back({1'b1, 8'h0F, 64'h00000000_D3D2D1D0});
    wait_words(0, 1);
    check_words(0, exq, "rst_fresh_word");

    // Randomized long streams with random downstream stalls.
    for (int idx = 1; idx < 3; idx++) begin
      bq.delete();
      for (int i = 0; i < 1000; i++) bq.push_back(8'($urandom));
      done_alone = $urandom_range(0, 1);
      exq        = model(idx == 1 ? 2 : 8, bq, done_alone);
      clear_cap(idx);
      stop = 0;
      fork
        begin
          send_stream(idx, bq, done_alone);
          stop = 1;
        end
        begin
          while (!stop) begin
            rdy[idx] = $urandom_range(0, 1);
            @(posedge clk);
            #1;
          end
        end
      join
      rdy[idx] = 1;
      wait_words(idx, exq.size());
      check_words(idx, exq, "rand_word");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
